// File: rtl/hi_lo_multiply_divide_unit.sv
// hi_lo_multiply_divide_unit
//
// Iterative radix-2 multiply/divide engine for MULT, MULTU, DIV and DIVU.
// It sits in the execute stage beside the ALU and produces the HI/LO results
// plus their write strobes. Each operation takes 34 cycles from the start
// edge to the end of the done pulse:
// the launch edge, DATA_WIDTH iteration edges, and one sign-fixup edge.
//
// Handshake: start is a valid-only request. It is accepted only in IDLE or
// DONE, and only when abort is low. While busy is high, start is ignored, so
// the hazard unit must stall. Because busy is registered, hazard logic must
// OR in start itself for the issue cycle. done and the HI/LO write strobes
// pulse for one cycle when a result is loaded. No ready back-pressure exists.
//
// Ports:
//   clk               rising-edge clock
//   reset_n           asynchronous active-low reset
//   start             mul/div request from execute; sampled in IDLE/DONE only
//   operation         00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   operand_a         Rs value (multiplicand / dividend)
//   operand_b         Rt value (multiplier / divisor)
//   abort             flush of the in-flight operation
//   busy              registered; high while iterating or fixing up
//   done              one-cycle pulse when the result is loaded
//   HI_register_write equals done
//   LO_register_write equals done
//   HI_result         product high word / remainder
//   LO_result         product low word / quotient
module hi_lo_multiply_divide_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            operation,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  HI_register_write,
    output logic                  LO_register_write,
    output logic [DATA_WIDTH-1:0] HI_result,
    output logic [DATA_WIDTH-1:0] LO_result
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [CW-1:0]           count;
    logic [2*DATA_WIDTH-1:0] acc;       // {high half, low half}
    logic [DATA_WIDTH-1:0]   b_mag;     // multiplicand addend or divisor magnitude
    logic                    sign_a;
    logic                    sign_b;
    logic                    is_div;
    logic                    div_zero;
    logic                    busy_q;
    logic                    done_q;

    logic                    launch;
    logic                    op_signed;
    logic                    a_neg;
    logic                    b_neg;
    logic [DATA_WIDTH-1:0]   a_mag_in;
    logic [DATA_WIDTH-1:0]   b_mag_in;

    logic [DATA_WIDTH:0]     mul_sum;
    logic [2*DATA_WIDTH-1:0] mul_next;
    logic [DATA_WIDTH:0]     div_shift;
    logic [DATA_WIDTH+1:0]   div_diff;
    logic [2*DATA_WIDTH-1:0] div_next;

    logic [2*DATA_WIDTH-1:0] prod_fixed;
    logic [DATA_WIDTH-1:0]   fix_hi;
    logic [DATA_WIDTH-1:0]   fix_lo;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start && !abort) begin
                    next_state = RUN;
                    launch     = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (count == LAST_COUNT) begin
                    next_state = FIXUP;
                end
            end
            FIXUP: begin
                next_state = abort ? IDLE : DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand conditioning: signed ops iterate on magnitudes
    // ------------------------------------------------------------------
    always_comb begin
        op_signed = operation[0];
        a_neg     = op_signed & operand_a[DATA_WIDTH-1];
        b_neg     = op_signed & operand_b[DATA_WIDTH-1];
        a_mag_in  = a_neg ? (~operand_a + 1'b1) : operand_a;
        b_mag_in  = b_neg ? (~operand_b + 1'b1) : operand_b;
    end

    // ------------------------------------------------------------------
    // One iteration of shift-add multiply and restoring divide
    // ------------------------------------------------------------------
    always_comb begin
        // Multiply: the low half holds the remaining multiplier bits, and
        // the product grows into the high half as it shifts right.
        mul_sum  = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                 + {1'b0, (acc[0] ? b_mag : {DATA_WIDTH{1'b0}})};
        mul_next = {mul_sum, acc[DATA_WIDTH-1:1]};

        // Divide: shift the next dividend bit into the remainder, then
        // subtract the divisor. A borrow restores the shifted value.
        div_shift = {acc[2*DATA_WIDTH-1:DATA_WIDTH], acc[DATA_WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_mag};
        if (div_diff[DATA_WIDTH+1]) begin
            div_next = {div_shift[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Sign fixup
    // ------------------------------------------------------------------
    always_comb begin
        prod_fixed = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
        if (is_div) begin
            // A zero divisor leaves the dividend magnitude in the remainder.
            // Re-applying the dividend sign therefore restores the original
            // operand_a, and the all-ones quotient bypasses the sign logic.
            fix_hi = sign_a ? (~acc[2*DATA_WIDTH-1:DATA_WIDTH] + 1'b1)
                            : acc[2*DATA_WIDTH-1:DATA_WIDTH];
            if (div_zero) begin
                fix_lo = {DATA_WIDTH{1'b1}};
            end else begin
                fix_lo = (sign_a ^ sign_b) ? (~acc[DATA_WIDTH-1:0] + 1'b1)
                                           : acc[DATA_WIDTH-1:0];
            end
        end else begin
            fix_hi = prod_fixed[2*DATA_WIDTH-1:DATA_WIDTH];
            fix_lo = prod_fixed[DATA_WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // State, datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            acc       <= '0;
            b_mag     <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            is_div    <= 1'b0;
            div_zero  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            HI_result <= '0;
            LO_result <= '0;
        end else begin
            state  <= next_state;
            busy_q <= (next_state == RUN) || (next_state == FIXUP);
            done_q <= (next_state == DONE);
            if (launch) begin
                count    <= '0;
                acc      <= {{DATA_WIDTH{1'b0}}, a_mag_in};
                b_mag    <= b_mag_in;
                sign_a   <= a_neg;
                sign_b   <= b_neg;
                is_div   <= operation[1];
                div_zero <= operation[1] && (operand_b == '0);
            end else if (state == RUN && !abort) begin
                count <= count + 1'b1;
                acc   <= is_div ? div_next : mul_next;
            end else if (state == FIXUP && !abort) begin
                HI_result <= fix_hi;
                LO_result <= fix_lo;
            end
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign HI_register_write = done_q;
    assign LO_register_write = done_q;

endmodule

// File: tb/tb_hi_lo_multiply_divide_unit.sv
// Directed testbench for hi_lo_multiply_divide_unit.
module tb_hi_lo_multiply_divide_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [1:0]   operation;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         abort;
    logic         busy;
    logic         done;
    logic         HI_register_write;
    logic         LO_register_write;
    logic [W-1:0] HI_result;
    logic [W-1:0] LO_result;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    hi_lo_multiply_divide_unit #(.DATA_WIDTH(W)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .operation         (operation),
        .operand_a         (operand_a),
        .operand_b         (operand_b),
        .abort             (abort),
        .busy              (busy),
        .done              (done),
        .HI_register_write (HI_register_write),
        .LO_register_write (LO_register_write),
        .HI_result         (HI_result),
        .LO_result         (LO_result)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // ---------------- drivers ----------------
    // Presents a request and returns 1 time unit after the accepting edge (E0).
    task automatic launch(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        @(negedge clk);
        start     = 1'b1;
        operation = op;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Entered at E0+1. It checks that busy is high and done is low across
    // E0..E32, and that the result appears at E33+1 with busy low.
    // inject > 0 pulses a spurious start so that it is sampled at that edge.
    task automatic expect_result(input string tag, input logic [W-1:0] exp_hi,
                                 input logic [W-1:0] exp_lo, input int inject);
        int bad;
        bad = 0;
        for (int i = 0; i < 33; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            if (inject > 0 && i == inject - 1) begin
                start     = 1'b1;
                operation = OP_MULTU;
                operand_a = 32'd100;
                operand_b = 32'd100;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check({tag, "_busy_window"}, 64'(bad), 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_strobes"}, {62'd0, HI_register_write, LO_register_write}, 64'd3);
        check({tag, "_busy_in_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_hi"}, {32'd0, HI_result}, {32'd0, exp_hi});
        check({tag, "_lo"}, {32'd0, LO_result}, {32'd0, exp_lo});
    endtask

    // Called during the DONE cycle when no follow-on request is made.
    task automatic end_done(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, {62'd0, done, busy}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int seen;
        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        operation = 2'b00;
        operand_a = '0;
        operand_b = '0;
        #3;
        check("reset_outputs", {busy, done, HI_register_write, LO_register_write, HI_result, LO_result}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Unsigned full-scale multiply
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expect_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 0);
        end_done("multu_max");

        // Signed multiplies
        launch(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        expect_result("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
        end_done("mult_neg");
        launch(OP_MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFA);
        expect_result("mult_negneg", 32'h0000_0000, 32'h0000_0018, 0);
        end_done("mult_negneg");

        // Signed divides
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        expect_result("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        end_done("div_neg");
        launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_result("div_ovf", 32'h0000_0000, 32'h8000_0000, 0);
        end_done("div_ovf");

        // Divide by zero
        launch(OP_DIVU, 32'd100, 32'd0);
        expect_result("divu_zero", 32'h0000_0064, 32'hFFFF_FFFF, 0);
        end_done("divu_zero");
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd0);
        expect_result("div_zero_neg", 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);
        end_done("div_zero_neg");

        // start together with abort in IDLE is ignored
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        operation = OP_MULTU;
        operand_a = 32'd3;
        operand_b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        check("abort_with_start_idle", {62'd0, busy, done}, 64'd0);

        // Abort in RUN: the abort is sampled at E10
        launch(OP_MULTU, 32'd2, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy_low", {63'd0, busy}, 64'd0);
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        check("abort_results_kept", {HI_result, LO_result}, {32'hFFFF_FFF9, 32'hFFFF_FFFF});

        // Restart at once, with a spurious start sampled at E5
        launch(OP_MULTU, 32'd7, 32'd6);
        expect_result("mul_inject", 32'd0, 32'd42, 5);
        end_done("mul_inject");

        // Back-to-back: the next request is made during the DONE cycle
        launch(OP_DIVU, 32'd9, 32'd4);
        expect_result("divu_first", 32'd1, 32'd2, 0);
        start     = 1'b1;
        operation = OP_DIVU;
        operand_a = 32'd100;
        operand_b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        expect_result("divu_b2b", 32'd2, 32'd14, 0);
        end_done("divu_b2b");

        // Asynchronous reset between edges at E20
        launch(OP_MULTU, 32'd11, 32'd13);
        repeat (20) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", {busy, done, HI_register_write, LO_register_write, HI_result, LO_result}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        check("post_reset_idle", 64'(seen), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
